oam_write_drain: RTL and testbench
==================================

// Module: oam_write_drain
// PURPOSE
//  Responder for the CPU OAM write port. The MEM stage issues OAMWrite requests
//  with an address and data. This block captures each request in a FIFO and
//  replays it to the sprite OAM port only while the PPU reports vblank and the
//  port is ready. The CPU never contends with the PPU for OAM during active
//  display. It sits between the CPU and the OAM RAM, next to the data-memory
//  interface.
// PARAMETERS
//  DEPTH   8    FIFO entries; power of two, >= 2
//  ADDR_W  8    OAM word-address width
//  DATA_W  32   OAM word width
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous reset, active-low
//  cpu_oam_we    in   1       CPU OAM write request, one word per cycle
//  cpu_oam_addr  in   ADDR_W  CPU OAM word address
//  cpu_oam_data  in   DATA_W  CPU OAM write data
//  cpu_stall     out  1       FIFO full; CPU must hold its request (combinational from count)
//  vblank        in   1       PPU vertical-blank window open
//  oam_ready     in   1       OAM port free this cycle
//  oam_we        out  1       registered OAM write strobe
//  oam_addr      out  ADDR_W  registered OAM address
//  oam_wdata     out  DATA_W  registered OAM data
//  pending       out  log2(DEPTH)+1  entries held in FIFO
//  overflow      out  1       sticky: a write was presented while full
//  clr_overflow  in   1       clears overflow (synchronous)
// BEHAVIOUR
//  Reset (rst=0, asynchronous): FIFO pointers = 0, pending = 0, state = IDLE,
//   oam_we = 0, oam_addr = 0, oam_wdata = 0, overflow = 0, cpu_stall = 0.
//  Push: cpu_oam_we && !full writes the entry at the write pointer, and the
//   pointer increments mod DEPTH.
//  While full, cpu_stall = 1 and a push is rejected, even if a pop happens in
//   the same cycle. A rejected push sets overflow.
//  If clr_overflow and a rejected push occur in the same cycle, overflow = 1.
//  Pop: happens only in DRAIN when vblank && oam_ready && !empty. The head entry
//   is loaded into oam_addr/oam_wdata and oam_we = 1 on the next edge.
//   oam_we is a single-cycle pulse per pop.
//  There is no bypass: a push into an empty FIFO becomes visible to the pop
//   logic one cycle later.
//  Latency: a push accepted at edge N gives an earliest oam_we at edge N+2
//   (vblank=1, oam_ready=1, state already DRAIN).
//  Simultaneous push and pop (not full, not empty): pending is unchanged and
//   both pointers advance.
//  Pointer wrap: the read and write pointers wrap at DEPTH-1 -> 0.
//   full  = (pending == DEPTH)
//   empty = (pending == 0)
//  Order: entries drain strictly in FIFO order. There is no coalescing of
//   writes to the same address.
//  FSM states and transitions:
//   IDLE -> DRAIN when vblank && !empty.
//   DRAIN pops one entry per cycle while vblank && oam_ready.
//    oam_ready=0 stalls DRAIN with no pop and oam_we = 0 next cycle.
//   DRAIN -> IDLE when !vblank or empty.
//    A pop already registered completes. No pop is issued in the cycle
//    vblank is low.
//  vblank falling mid-drain: the remaining entries stay queued and resume at the
//   next vblank.
//  Reset mid-drain: all queued entries are discarded and oam_we drops immediately.
//  Addresses and data pass through unmodified. Width is exactly ADDR_W/DATA_W.
// TESTING
//  1. Reset, no writes, vblank toggling -> oam_we stays 0, pending = 0,
//     cpu_stall = 0.
//  2. vblank=0; push A=0x05/D=0x11223344, then A=0x06/D=0x55667788 -> pending = 2,
//     no oam_we. Raise vblank with oam_ready=1 -> two consecutive oam_we pulses
//     with addresses 0x05, 0x06 in order, then pending = 0.
//  3. vblank=0; 9 back-to-back pushes, DEPTH=8 -> cpu_stall = 1 after the 8th,
//     the 9th is rejected, overflow = 1. Pulse clr_overflow -> overflow = 0.
//  4. Draining 8 entries with vblank dropping after 3 pops -> exactly 3 oam_we,
//     pending = 5. At the next vblank the remaining 5 drain in order.
//  5. oam_ready held low for 4 cycles during DRAIN -> no oam_we in those cycles,
//     order is preserved, drain resumes when ready returns.
//  6. Full FIFO with push and pop in the same cycle -> push rejected, overflow = 1,
//     pending = 7. Async rst asserted mid-drain -> all outputs 0 before the next
//     clk edge.

Source files
------------

// File: rtl/oam_write_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// oam_write_drain
//
// Purpose:
//   This block responds to the CPU OAM write port. Every CPU write request
//   (address + data) is captured in a small FIFO. The block replays the queued
//   writes to the sprite OAM port only while the PPU reports vertical blank
//   and the OAM port is ready. The CPU therefore never competes with the PPU
//   for OAM during active display.
//
// Ports:
//   clk           in   1            system clock, rising edge
//   rst           in   1            asynchronous reset, active-low
//   cpu_oam_we    in   1            CPU OAM write request, one word per cycle
//   cpu_oam_addr  in   ADDR_W       CPU OAM word address
//   cpu_oam_data  in   DATA_W       CPU OAM write data
//   cpu_stall     out  1            FIFO full; CPU must hold its request
//   vblank        in   1            PPU vertical-blank window open
//   oam_ready     in   1            OAM port free this cycle
//   oam_we        out  1            registered OAM write strobe (1-cycle pulse)
//   oam_addr      out  ADDR_W       registered OAM address
//   oam_wdata     out  DATA_W       registered OAM data
//   pending       out  log2(DEPTH)+1 entries held in FIFO
//   overflow      out  1            sticky: a write was presented while full
//   clr_overflow  in   1            clears overflow (synchronous)
//   state_dbg     out  1            current drain FSM state (0 = IDLE, 1 = DRAIN)
//
// Handshake semantics:
//   CPU side : a word is accepted on a rising edge where cpu_oam_we=1 and
//              cpu_stall=0. cpu_stall is the inverse of ready and depends only
//              on the fill count. A word offered while cpu_stall=1 is dropped
//              and sets overflow. The CPU holds the word and retries it.
//   OAM side : a pop is committed on a rising edge where the FSM is in DRAIN,
//              vblank=1, oam_ready=1 and the FIFO is not empty. The popped word
//              shows up on oam_addr/oam_wdata with oam_we=1 for exactly one
//              cycle after that edge.
// -----------------------------------------------------------------------------
module oam_write_drain #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_oam_we,
  input  logic [ADDR_W-1:0]        cpu_oam_addr,
  input  logic [DATA_W-1:0]        cpu_oam_data,
  output logic                     cpu_stall,
  input  logic                     vblank,
  input  logic                     oam_ready,
  output logic                     oam_we,
  output logic [ADDR_W-1:0]        oam_addr,
  output logic [DATA_W-1:0]        oam_wdata,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     state_dbg
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Drain FSM states
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [0:0]         state_q;
  logic [0:0]         state_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic push_rejected;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A push is refused whenever the FIFO is full at the start of the cycle.
  // This holds even if a pop frees a slot in the same cycle. Keeping
  // cpu_stall a pure function of the count avoids a combinational path
  // from vblank/oam_ready back to the CPU.
  assign push          = cpu_oam_we && !full;
  assign push_rejected = cpu_oam_we && full;

  // There is no bypass: pop only looks at entries already counted, so a word
  // pushed into an empty FIFO becomes poppable one cycle later.
  assign pop = (state_q == DRAIN) && vblank && oam_ready && !empty;

  assign cpu_stall = full;
  assign pending   = count;
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // FIFO storage. The entry array has no reset: its contents are meaningful
  // only behind the pointers, and the pointers are reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cpu_oam_addr, cpu_oam_data};
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so pointer wrap from
  // DEPTH-1 back to 0 is just natural overflow of the PTR_W-bit adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  //   IDLE  -> DRAIN when vblank and there is something queued.
  //   DRAIN -> IDLE  when vblank closes or the FIFO has run dry. A pop that
  //                  was registered at the previous edge still finishes,
  //                  because oam_we is already registered.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vblank && !empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!vblank || empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered OAM write port. Address and data hold their last value between
  // pops. Only oam_we marks a valid write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oam_we    <= 1'b0;
      oam_addr  <= '0;
      oam_wdata <= '0;
    end else begin
      oam_we <= pop;
      if (pop) begin
        {oam_addr, oam_wdata} <= mem[rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow. Setting wins over clearing, so a refused write is never
  // lost when software clears the flag in that same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push_rejected) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oam_write_drain.sv
`timescale 1ns/1ps
module tb_oam_write_drain;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst;
  logic              cpu_oam_we;
  logic [ADDR_W-1:0] cpu_oam_addr;
  logic [DATA_W-1:0] cpu_oam_data;
  logic              cpu_stall;
  logic              vblank;
  logic              oam_ready;
  logic              oam_we;
  logic [ADDR_W-1:0] oam_addr;
  logic [DATA_W-1:0] oam_wdata;
  logic [3:0]        pending;
  logic              overflow;
  logic              clr_overflow;
  logic              state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  oam_write_drain #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_oam_we   (cpu_oam_we),
    .cpu_oam_addr (cpu_oam_addr),
    .cpu_oam_data (cpu_oam_data),
    .cpu_stall    (cpu_stall),
    .vblank       (vblank),
    .oam_ready    (oam_ready),
    .oam_we       (oam_we),
    .oam_addr     (oam_addr),
    .oam_wdata    (oam_wdata),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int we_count = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Every OAM write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && oam_we) begin
      we_count++;
      check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check("sb_addr_data", 64'({oam_addr, oam_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_oam_we   = 1'b1;
    cpu_oam_addr = a;
    cpu_oam_data = d;
    tick();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((pending != 0 || oam_we) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_in_time", 64'(n < max_cycles), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst          = 1'b0;
    cpu_oam_we   = 1'b0;
    cpu_oam_addr = '0;
    cpu_oam_data = '0;
    vblank       = 1'b0;
    oam_ready    = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_oam_we",    64'(oam_we),    64'd0);
    check("rst_pending",   64'(pending),   64'd0);
    check("rst_stall",     64'(cpu_stall), 64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_oam_addr",  64'(oam_addr),  64'd0);
    check("rst_oam_wdata", 64'(oam_wdata), 64'd0);
    check("rst_state",     64'(state_dbg), 64'd0);
    rst = 1'b1;

    // 1: vblank toggling with nothing queued
    oam_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vblank = i[0];
      tick();
    end
    check("t1_no_we",    64'(we_count),  64'd0);
    check("t1_pending",  64'(pending),   64'd0);
    check("t1_stall",    64'(cpu_stall), 64'd0);

    // 2: two queued writes drain as consecutive pulses
    vblank = 1'b0;
    exp_q.push_back({8'h05, 32'h11223344});
    drive_push(8'h05, 32'h11223344);
    exp_q.push_back({8'h06, 32'h55667788});
    drive_push(8'h06, 32'h55667788);
    cpu_oam_we = 1'b0;
    tick();
    check("t2_pending2", 64'(pending),  64'd2);
    check("t2_no_we",    64'(we_count), 64'd0);
    vblank = 1'b1;
    tick();                                   // IDLE -> DRAIN
    check("t2_we_e1",    64'(oam_we),   64'd0);
    check("t2_state",    64'(state_dbg), 64'd1);
    tick();
    check("t2_we_e2",    64'(oam_we),   64'd1);
    check("t2_addr_e2",  64'(oam_addr), 64'h05);
    tick();
    check("t2_we_e3",    64'(oam_we),   64'd1);
    check("t2_addr_e3",  64'(oam_addr), 64'h06);
    check("t2_data_e3",  64'(oam_wdata), 64'h55667788);
    tick();
    check("t2_we_e4",    64'(oam_we),   64'd0);
    check("t2_pending0", 64'(pending),  64'd0);
    vblank = 1'b0;

    // 3: nine pushes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({8'(8'h10 + i), 32'hA000_0000 + 32'(i)});
      drive_push(8'(8'h10 + i), 32'hA000_0000 + 32'(i));
      if (i == 6) check("t3_stall_at7", 64'(cpu_stall), 64'd0);
      if (i == 7) check("t3_stall_at8", 64'(cpu_stall), 64'd1);
    end
    cpu_oam_we = 1'b0;
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_pending8", 64'(pending),  64'd8);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3_ovf_clr",  64'(overflow), 64'd0);

    // 4: vblank drops after three pops, rest drains next vblank
    base   = we_count;
    vblank = 1'b1;
    repeat (4) tick();
    vblank = 1'b0;
    repeat (3) tick();
    check("t4_three_we", 64'(we_count - base), 64'd3);
    check("t4_pending5", 64'(pending),          64'd5);
    check("t4_idle",     64'(state_dbg),        64'd0);
    vblank = 1'b1;
    wait_drain(30);
    check("t4_eight_we", 64'(we_count - base), 64'd8);
    vblank = 1'b0;

    // 5: oam_ready low for 4 cycles during DRAIN
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({8'(8'h20 + i), 32'hC0DE_0000 + 32'(i)});
      drive_push(8'(8'h20 + i), 32'hC0DE_0000 + 32'(i));
    end
    cpu_oam_we = 1'b0;
    base   = we_count;
    vblank = 1'b1;
    tick();                                   // IDLE -> DRAIN
    tick();
    check("t5_first_we",   64'(oam_we),   64'd1);
    check("t5_first_addr", 64'(oam_addr), 64'h20);
    oam_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_hold_no_we", 64'(oam_we), 64'd0);
    end
    check("t5_pending3", 64'(pending), 64'd3);
    oam_ready = 1'b1;
    wait_drain(30);
    check("t5_four_we",  64'(we_count - base), 64'd4);
    vblank = 1'b0;

    // 6: push while full with a pop in the same cycle, then async reset
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({8'(8'h30 + i), 32'h3300_0000 + 32'(i)});
      drive_push(8'(8'h30 + i), 32'h3300_0000 + 32'(i));
    end
    cpu_oam_we = 1'b0;
    vblank     = 1'b1;
    tick();                                   // IDLE -> DRAIN
    cpu_oam_we   = 1'b1;
    cpu_oam_addr = 8'h99;
    cpu_oam_data = 32'hDEAD_BEEF;
    tick();                                   // pop + rejected push
    cpu_oam_we = 1'b0;
    check("t6_overflow", 64'(overflow), 64'd1);
    check("t6_pending7", 64'(pending),  64'd7);
    check("t6_we",       64'(oam_we),   64'd1);
    check("t6_addr",     64'(oam_addr), 64'h30);
    tick();
    check("t6_we2",      64'(oam_we),   64'd1);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_we",       64'(oam_we),    64'd0);
    check("t6_rst_pending",  64'(pending),   64'd0);
    check("t6_rst_overflow", 64'(overflow),  64'd0);
    check("t6_rst_stall",    64'(cpu_stall), 64'd0);
    check("t6_rst_addr",     64'(oam_addr),  64'd0);
    check("t6_rst_wdata",    64'(oam_wdata), 64'd0);
    check("t6_rst_state",    64'(state_dbg), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    check("t6_post_we",      64'(oam_we),  64'd0);
    check("t6_post_pending", 64'(pending), 64'd0);

    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
